lifo_pop_streamer: RTL

- Read-side master for the LIFO: accepts a pop command of N words and drives the LIFO read port (`rdreq`/`q`/`empty`/`usedw`).
- Returns the popped words as a valid/ready stream, with `last` on word N.
- A 2-entry output buffer absorbs the LIFO's 1-cycle read latency, so it sustains 1 word/clk under continuous `ready`.
- Sits between the LIFO and any downstream consumer. It is the only agent allowed to assert the LIFO's `rdreq`.

---
 rtl/lifo_pop_streamer_if.sv | 30 +++
 rtl/lifo_pop_streamer.sv | 118 +++++++++++
 2 files changed

// File: rtl/lifo_pop_streamer_if.sv
// Bundles the LIFO read-side master's command, LIFO read port and output stream.
// master = the streamer itself; slave = the LIFO plus command source and stream sink.
interface lifo_pop_streamer_if #(
  parameter int unsigned DWIDTH = 16,
  parameter int unsigned AWIDTH = 8
);
  logic              cmd_valid_i;
  logic [AWIDTH:0]   cmd_len_i;
  logic              cmd_ready_o;
  logic              cmd_err_o;
  logic              rdreq_o;
  logic [DWIDTH-1:0] q_i;
  logic              empty_i;
  logic [AWIDTH:0]   usedw_i;
  logic [DWIDTH-1:0] data_o;
  logic              valid_o;
  logic              last_o;
  logic              ready_i;
  logic              busy_o;

  modport master (
    input  cmd_valid_i, cmd_len_i, q_i, empty_i, usedw_i, ready_i,
    output cmd_ready_o, cmd_err_o, rdreq_o, data_o, valid_o, last_o, busy_o
  );

  modport slave (
    output cmd_valid_i, cmd_len_i, q_i, empty_i, usedw_i, ready_i,
    input  cmd_ready_o, cmd_err_o, rdreq_o, data_o, valid_o, last_o, busy_o
  );
endinterface

// File: rtl/lifo_pop_streamer.sv
// Pops N words from a LIFO and replays them as a valid/ready stream with last on word N.
// A 2-entry skid FIFO hides the LIFO's 1-cycle read latency for 1 word/clk throughput.
module lifo_pop_streamer #(
  parameter int unsigned DWIDTH = 16,
  parameter int unsigned AWIDTH = 8
) (
  input  logic clk,
  input  logic srst,
  lifo_pop_streamer_if.master bus
);
  localparam int unsigned LW = AWIDTH + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state;
  logic [LW-1:0]     remaining;
  logic [DWIDTH-1:0] buf_data [2];
  logic [1:0]        buf_last;
  logic              rd_ptr;
  logic              wr_ptr;
  logic [1:0]        occ;
  logic              inflight;
  logic              inflight_last;
  logic              push;
  logic              pop;
  logic              rd_ok;
  logic              rd_is_last;

  assign pop        = bus.valid_o && bus.ready_i;
  assign push       = inflight;
  assign rd_is_last = (remaining == LW'(1));

  // Issue a read only if its data is guaranteed a buffer slot when it lands.
  assign rd_ok = (state == RUN) && !bus.empty_i && (remaining != '0) &&
                 (((occ + 2'(inflight)) < 2'd2) || pop);

  assign bus.rdreq_o = rd_ok;
  assign bus.valid_o = (occ != 2'd0);
  assign bus.data_o  = buf_data[rd_ptr];
  assign bus.last_o  = buf_last[rd_ptr];

  always_ff @(posedge clk) begin
    if (srst) begin
      state           <= IDLE;
      remaining       <= '0;
      buf_data[0]     <= '0;
      buf_data[1]     <= '0;
      buf_last        <= 2'b00;
      rd_ptr          <= 1'b0;
      wr_ptr          <= 1'b0;
      occ             <= 2'd0;
      inflight        <= 1'b0;
      inflight_last   <= 1'b0;
      bus.cmd_ready_o <= 1'b1;
      bus.cmd_err_o   <= 1'b0;
      bus.busy_o      <= 1'b0;
    end else begin
      bus.cmd_err_o <= 1'b0;

      if (push) begin
        buf_data[wr_ptr] <= bus.q_i;
        buf_last[wr_ptr] <= inflight_last;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: ;
      endcase

      inflight      <= rd_ok;
      inflight_last <= rd_ok && rd_is_last;
      if (rd_ok) begin
        remaining <= remaining - LW'(1);
      end

      case (state)
        IDLE: begin
          if (bus.cmd_valid_i) begin
            if (bus.cmd_len_i == '0) begin
              state <= IDLE;
            end else if (bus.cmd_len_i > bus.usedw_i) begin
              bus.cmd_err_o <= 1'b1;
            end else begin
              remaining       <= bus.cmd_len_i;
              state           <= RUN;
              bus.cmd_ready_o <= 1'b0;
              bus.busy_o      <= 1'b1;
            end
          end
        end
        RUN: begin
          if (rd_ok && rd_is_last) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && bus.last_o) begin
            state           <= IDLE;
            bus.cmd_ready_o <= 1'b1;
            bus.busy_o      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The read-issue rule must keep the skid buffer within its two entries.
  always_ff @(posedge clk) begin
    if (!srst) begin
      assert (occ != 2'd3);
    end
  end
endmodule
